// File: rtl/calc_pkg.sv
// calc_pkg: key codes, keypad map and scanner FSM states shared by the calculator blocks.
package calc_pkg;
   typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;
   localparam logic [3:0] KEY_0 = 4'h0, KEY_1 = 4'h1, KEY_2 = 4'h2, KEY_3 = 4'h3,
                          KEY_4 = 4'h4, KEY_5 = 4'h5, KEY_6 = 4'h6, KEY_7 = 4'h7,
                          KEY_8 = 4'h8, KEY_9 = 4'h9, KEY_A = 4'hA, KEY_B = 4'hB,
                          KEY_C = 4'hC, KEY_D = 4'hD, KEY_E = 4'hE, KEY_F = 4'hF;
   // Entry {row,col} sits at nibble row*4+col; listed from row 3/col 3 down to row 0/col 0.
   localparam logic [63:0] KEY_MAP = {KEY_D, KEY_E, KEY_F, KEY_0, KEY_C, KEY_9, KEY_8, KEY_7,
                                      KEY_B, KEY_6, KEY_5, KEY_4, KEY_A, KEY_3, KEY_2, KEY_1};
   function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
      return KEY_MAP[{row, col, 2'b00} +: 4];
   endfunction
endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad pins plus the key event outputs toward the calculator core.
interface keypad_scanner_if;
   logic [3:0] row_n;
   logic [3:0] col_n;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;
   modport master(input row_n, output col_n, key_code, key_valid, key_held);
   modport slave(output row_n, input col_n, key_code, key_valid, key_held);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for asynchronous board inputs, resets to all ones.
module sync_2ff #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         clr,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] meta;
   always_ff @(posedge clk) begin
      if (clr) begin
         meta <= '1;
         q    <= '1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: walks an active-low column strobe over a 4x4 keypad, builds a scan image,
// debounces whole scans and reports one key code per accepted press.
module keypad_scanner
   import calc_pkg::*;
#(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input logic               clk,
   input logic               clr,
   keypad_scanner_if.master  kp
);
   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
   logic [DW-1:0] div;
   logic [1:0]    col;
   logic [3:0]    rows;
   logic [15:0]   image, img_n;
   logic [3:0]    k;
   logic          term, scan_end, none, single;
   state_t        state, state_n;
   logic [3:0]    cand, cand_n, code, code_n;
   logic [CW-1:0] cnt, cnt_n, cnt_inc;
   logic          valid, valid_n, held, held_n;
   sync_2ff #(.W(4)) u_sync (.clk(clk), .clr(clr), .d(kp.row_n), .q(rows));
   assign term     = div == DW'(SCAN_DIV - 1);
   assign scan_end = term && col == 2'd3;
   assign kp.col_n = ~(4'b0001 << col);
   assign kp.key_code  = code;
   assign kp.key_valid = valid;
   assign kp.key_held  = held;
   // Classification looks at the image including the sample taken this very cycle.
   always_comb begin
      img_n = image;
      k = '0;
      for (int r = 0; r < 4; r++) if (term && !rows[r]) img_n[{r[1:0], col}] = 1'b1;
      for (int i = 0; i < 16; i++) if (img_n[i]) k = key_map(i[3:2], i[1:0]);
   end
   assign none    = img_n == '0;
   assign single  = $onehot(img_n);
   assign cnt_inc = (cnt == CW'(DEBOUNCE_SCANS)) ? cnt : cnt + CW'(1);
   always_comb begin
      state_n = state;
      cand_n  = cand;
      cnt_n   = cnt;
      code_n  = code;
      valid_n = 1'b0;
      held_n  = held;
      if (scan_end) begin
         case (state)
            IDLE: if (single) begin
               cand_n  = k;
               cnt_n   = CW'(1);
               state_n = DEBOUNCE;
            end
            DEBOUNCE: if (single && k == cand) begin
               cnt_n = cnt_inc;
               if (cnt_inc == CW'(DEBOUNCE_SCANS)) begin
                  code_n  = cand;
                  valid_n = 1'b1;
                  held_n  = 1'b1;
                  state_n = PRESSED;
               end
            end else if (single) begin
               cand_n = k;
               cnt_n  = CW'(1);
            end else state_n = IDLE;
            PRESSED: if (none) begin
               cnt_n   = CW'(1);
               state_n = RELEASE;
            end
            RELEASE: if (none) begin
               cnt_n = cnt_inc;
               if (cnt_inc == CW'(DEBOUNCE_SCANS)) begin
                  held_n  = 1'b0;
                  state_n = IDLE;
               end
            end else state_n = PRESSED;
            default: state_n = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (clr) begin
         div   <= '0;
         col   <= '0;
         image <= '0;
         state <= IDLE;
         cand  <= '0;
         cnt   <= '0;
         code  <= '0;
         valid <= 1'b0;
         held  <= 1'b0;
      end else begin
         div   <= term ? '0 : div + DW'(1);
         col   <= term ? col + 2'd1 : col;
         image <= scan_end ? '0 : img_n;
         state <= state_n;
         cand  <= cand_n;
         cnt   <= cnt_n;
         code  <= code_n;
         valid <= valid_n;
         held  <= held_n;
      end
   end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed keypad scenarios; expected key codes are queued by the stimulus
// and popped by a monitor on every key_valid pulse.
module tb_keypad_scanner;
   localparam int SD = 4;
   localparam int DS = 3;
   localparam int SCAN = 4 * SD;
   logic clk = 1'b0;
   logic clr = 1'b1;
   logic [3:0] press [4];
   logic [3:0] exp_q [$];
   int checks = 0;
   int errors = 0;
   keypad_scanner_if kp();
   keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (.clk(clk), .clr(clr), .kp(kp));
   always #5 clk = ~clk;
   always_comb begin
      kp.row_n = '1;
      for (int r = 0; r < 4; r++) kp.row_n[r] = ~|(press[r] & ~kp.col_n);
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic scans(input int n);
      repeat (n * SCAN) @(negedge clk);
   endtask
   task automatic release_all();
      for (int r = 0; r < 4; r++) press[r] = 4'b0000;
   endtask
   // Leaves the bench at the falling edge of the first cycle of a scan (column 0, divider 0).
   task automatic align();
      int t = 0;
      while (kp.col_n != 4'b0111 && t < 64) begin @(negedge clk); t++; end
      while (kp.col_n != 4'b1110 && t < 64) begin @(negedge clk); t++; end
      if (t >= 64) chk("align_timeout", t, 0);
   endtask
   always @(negedge clk) begin
      if (kp.key_valid) begin
         if (exp_q.size() == 0) chk("unexpected_key_valid", {28'd0, kp.key_code}, 32'hFFFF_FFFF);
         else chk("key_valid_code", {28'd0, kp.key_code}, {28'd0, exp_q.pop_front()});
      end
   end
   initial begin
      release_all();
      // 1: reset and idle column walk
      @(negedge clk);
      @(negedge clk);
      clr = 1'b0;
      chk("t1_col0", kp.col_n, 4'b1110);
      chk("t1_code", kp.key_code, 0);
      chk("t1_valid", kp.key_valid, 0);
      chk("t1_held", kp.key_held, 0);
      repeat (SD) @(negedge clk);
      chk("t1_col1", kp.col_n, 4'b1101);
      repeat (SD) @(negedge clk);
      chk("t1_col2", kp.col_n, 4'b1011);
      repeat (SD) @(negedge clk);
      chk("t1_col3", kp.col_n, 4'b0111);
      repeat (SD) @(negedge clk);
      chk("t1_wrap", kp.col_n, 4'b1110);
      chk("t1_held_idle", kp.key_held, 0);
      // 2: hold '5' six scans, then release
      align();
      press[1][1] = 1'b1;
      exp_q.push_back(4'h5);
      scans(3);
      chk("t2_held", kp.key_held, 1);
      scans(3);
      chk("t2_one_pulse", exp_q.size(), 0);
      release_all();
      scans(2);
      chk("t2_held_bounce_window", kp.key_held, 1);
      scans(1);
      chk("t2_held_dropped", kp.key_held, 0);
      chk("t2_code_kept", kp.key_code, 4'h5);
      // 3: short '9' presses never accepted
      align();
      press[2][2] = 1'b1;
      scans(2);
      chk("t3_held_a", kp.key_held, 0);
      release_all();
      scans(1);
      press[2][2] = 1'b1;
      scans(2);
      chk("t3_held_b", kp.key_held, 0);
      release_all();
      scans(2);
      chk("t3_held_c", kp.key_held, 0);
      chk("t3_code", kp.key_code, 4'h5);
      // 4: '1'+'2' together, then drop '2'
      align();
      press[0][0] = 1'b1;
      press[0][1] = 1'b1;
      scans(4);
      chk("t4_multi_held", kp.key_held, 0);
      press[0][1] = 1'b0;
      exp_q.push_back(4'h1);
      scans(3);
      chk("t4_held", kp.key_held, 1);
      release_all();
      scans(4);
      chk("t4_code", kp.key_code, 4'h1);
      chk("t4_pulse_seen", exp_q.size(), 0);
      // 5: clear while 'D' is pressed
      align();
      press[3][3] = 1'b1;
      exp_q.push_back(4'hD);
      scans(3);
      chk("t5_held", kp.key_held, 1);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("t5_clr_code", kp.key_code, 0);
      chk("t5_clr_valid", kp.key_valid, 0);
      chk("t5_clr_held", kp.key_held, 0);
      chk("t5_clr_col", kp.col_n, 4'b1110);
      exp_q.push_back(4'hD);
      scans(2);
      chk("t5_not_yet", kp.key_held, 0);
      scans(1);
      chk("t5_reheld", kp.key_held, 1);
      release_all();
      scans(4);
      chk("t5_code", kp.key_code, 4'hD);
      chk("t5_pulses_seen", exp_q.size(), 0);
      // 6: release bounce into a different key
      align();
      press[3][0] = 1'b1;
      exp_q.push_back(4'h0);
      scans(3);
      release_all();
      scans(1);
      press[0][3] = 1'b1;
      scans(2);
      chk("t6_held", kp.key_held, 1);
      chk("t6_code", kp.key_code, 4'h0);
      release_all();
      scans(4);
      chk("t6_released", kp.key_held, 0);
      chk("t6_code_kept", kp.key_code, 4'h0);
      chk("final_queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
